// File: rtl/root_engine_arbiter_pkg.sv
// root_pkg: shared widths, default timeout and FSM state encoding for the root engine arbiter
package root_pkg;
  localparam int RAD_W = 10;
  localparam int ORD_W = 3;
  localparam int RES_W = 20;
  localparam int TIMEOUT_DEF = 1023;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN, ERST} state_t;
endpackage

// File: rtl/root_engine_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant from a registered pointer advanced on accept
module rr_arbiter #(
  parameter int N = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           accept,
  output logic           any,
  output logic [IDW-1:0] idx,
  output logic [N-1:0]   gnt
);
  logic [IDW-1:0] ptr;
  logic [IDW:0]   s;
  logic [IDW-1:0] j;
  always_comb begin
    any = 1'b0;
    idx = '0;
    s = '0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr} + (IDW+1)'(k);
      j = IDW'(s >= (IDW+1)'(N) ? s - (IDW+1)'(N) : s);
      if (!any && req[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
    gnt = any ? N'(1) << idx : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= '0;
    else if (accept) ptr <= idx == IDW'(N-1) ? '0 : idx + 1'b1;
  end
endmodule

// File: rtl/root_engine_arbiter.sv
// root_engine_arbiter: shares one hazard-prone root engine among N requesters with tagged responses
module root_engine_arbiter
  import root_pkg::*;
#(
  parameter int N = 4,
  parameter int IDW = 2,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req_valid,
  input  logic [N*RAD_W-1:0] req_data_1,
  input  logic [N*ORD_W-1:0] req_data_2,
  output logic [N-1:0]       req_ready,
  output logic               resp_valid,
  output logic [IDW-1:0]     resp_id,
  output logic [RES_W-1:0]   resp_data,
  output logic               resp_err,
  output logic               eng_in_valid,
  output logic [RAD_W-1:0]   eng_data_1,
  output logic [ORD_W-1:0]   eng_data_2,
  input  logic               eng_out_valid,
  input  logic [RES_W-1:0]   eng_out_data,
  output logic               eng_soft_rst_n
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TOP = CW'(TIMEOUT);
  state_t state, state_n;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] gnt_q, idx;
  logic [N-1:0]   gnt;
  logic           any;
  rr_arbiter #(.N(N), .IDW(IDW)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req_valid), .accept(state == IDLE && any),
    .any(any), .idx(idx), .gnt(gnt)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any) state_n = req_data_2[idx*ORD_W +: ORD_W] == '0 ? RESP : ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    state_n = eng_out_valid ? RESP : cnt == TOP ? ERST : WAIT;
      RESP:    state_n = resp_err ? IDLE : DRAIN;
      DRAIN:   state_n = eng_out_valid ? DRAIN : IDLE;
      ERST:    state_n = cnt == CW'(1) ? RESP : ERST;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      gnt_q <= '0;
      req_ready <= '0;
      resp_valid <= 1'b0;
      resp_id <= '0;
      resp_data <= '0;
      resp_err <= 1'b0;
      eng_in_valid <= 1'b0;
      eng_data_1 <= '0;
      eng_data_2 <= '0;
      eng_soft_rst_n <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? '0 : cnt == TOP ? cnt : cnt + 1'b1;
      req_ready <= state == IDLE && state_n != IDLE ? gnt : '0;
      eng_in_valid <= state == IDLE && state_n == ISSUE;
      eng_soft_rst_n <= state_n != ERST;
      resp_valid <= state_n == RESP;
      if (state == IDLE && any) begin
        gnt_q <= idx;
        eng_data_1 <= req_data_1[idx*RAD_W +: RAD_W];
        eng_data_2 <= req_data_2[idx*ORD_W +: ORD_W];
      end
      if (state_n == RESP && state != RESP) begin
        resp_id <= state == IDLE ? idx : gnt_q;
        resp_err <= state != WAIT;
        resp_data <= state == WAIT ? eng_out_data : '0;
      end
    end
  end
endmodule
